mem_region_mux: RTL and testbench

Parametrised memory-bus router between the RudolV pipeline data/instruction port and up to REGIONS memory slaves (BRAM, boot ROM, LUT RAM), replacing the hard-wired two-way main/boot split in board tops. Decodes each access by base/mask, routes write strobes, registers the read select for the 1-cycle-latency return path, gates grubby tags per region, and enforces read-only regions. Unmapped accesses and writes to read-only regions are logged in a CSR-visible fault register with an optional interrupt.

---
 rtl/mem_region_mux.sv | 153 +++++++++++++++
 tb/tb_mem_region_mux.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_region_mux.sv
// Memory-bus router from the RudolV data/instruction port to REGIONS slaves,
// with base/mask decode, read-only enforcement, grubby gating and a fault CSR.
module mem_region_mux #(
  parameter int unsigned             REGIONS   = 2,
  parameter logic [REGIONS*32-1:0]   BASE      = {32'h0002_0000, 32'h0000_0000},
  parameter logic [REGIONS*32-1:0]   MASK      = {32'hFFFF_FF80, 32'hFFFF_0000},
  parameter logic [REGIONS-1:0]      RO        = 2'b10,
  parameter logic [REGIONS-1:0]      GRUBBY_EN = 2'b01,
  parameter logic [11:0]             CSR_BASE  = 12'hBC3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   mem_valid,
  input  logic                   mem_write,
  input  logic [31:0]            mem_addr,
  output logic [31:0]            mem_rdata,
  output logic                   mem_rgrubby,
  output logic [REGIONS-1:0]     slv_write,
  input  logic [REGIONS*32-1:0]  slv_rdata,
  input  logic [REGIONS-1:0]     slv_rgrubby,
  input  logic                   grubby_switch,
  input  logic                   csr_read,
  input  logic [2:0]             csr_modify,
  input  logic [31:0]            csr_wdata,
  input  logic [11:0]            csr_addr,
  output logic [31:0]            csr_rdata,
  output logic                   csr_valid,
  output logic                   fault_irq
);

  localparam int unsigned SELW = (REGIONS > 1) ? $clog2(REGIONS) : 1;

  logic [REGIONS-1:0] hit_s;
  logic [SELW-1:0]    sel_s;
  logic               any_hit_s;
  logic               fault_s;

  logic [SELW-1:0]    q_sel_q;
  logic               q_miss_q;
  logic               gmeta_q, gsync_q;
  logic               pending_q, pending_d;
  logic               kind_q, kind_d;
  logic [7:0]         count_q, count_d;
  logic               irq_en_q, irq_en_d;
  logic [31:0]        faddr_q, faddr_d;
  logic               fault_irq_q;

  logic [31:0]        rd_sel_s;
  logic               rg_sel_s;
  logic               status_hit_s, faddr_hit_s, status_mod_s, clr_s;
  logic               unused_s;

  assign unused_s = ^{csr_wdata[31:17], csr_wdata[15:1]};

  // Address decode; scanning downwards leaves the lowest hitting index in sel_s.
  always_comb begin
    hit_s     = '0;
    sel_s     = '0;
    slv_write = '0;
    for (int i = 0; i < int'(REGIONS); i++) begin
      hit_s[i] = ((mem_addr & MASK[32*i +: 32]) == BASE[32*i +: 32]);
    end
    for (int i = int'(REGIONS) - 1; i >= 0; i--) begin
      sel_s = hit_s[i] ? SELW'(i) : sel_s;
    end
    any_hit_s = |hit_s;
    for (int i = 0; i < int'(REGIONS); i++) begin
      slv_write[i] = mem_valid & mem_write & hit_s[i] & (sel_s == SELW'(i)) & ~RO[i];
    end
    fault_s = mem_valid & (~any_hit_s | (mem_write & RO[sel_s]));
  end

  // Return-path mux driven by the select registered on the previous cycle.
  always_comb begin
    rd_sel_s = '0;
    rg_sel_s = 1'b0;
    for (int i = 0; i < int'(REGIONS); i++) begin
      rd_sel_s = (q_sel_q == SELW'(i)) ? slv_rdata[32*i +: 32] : rd_sel_s;
      rg_sel_s = (q_sel_q == SELW'(i)) ? (slv_rgrubby[i] & GRUBBY_EN[i]) : rg_sel_s;
    end
    mem_rdata   = q_miss_q ? 32'h0000_0000 : rd_sel_s;
    mem_rgrubby = ~q_miss_q & rg_sel_s & gsync_q;
  end

  assign status_hit_s = (csr_addr == CSR_BASE);
  assign faddr_hit_s  = (csr_addr == (CSR_BASE + 12'd1));
  assign status_mod_s = status_hit_s & (csr_modify != 3'd0);
  assign clr_s        = status_mod_s & csr_wdata[0];

  // CSR claim and read mux.
  always_comb begin
    csr_valid = (status_hit_s | faddr_hit_s) & (csr_read | (csr_modify != 3'd0));
    csr_rdata = 32'h0000_0000;
    if (csr_valid && status_hit_s) begin
      csr_rdata = {15'd0, irq_en_q, count_q, 6'd0, kind_q, pending_q};
    end else if (csr_valid) begin
      csr_rdata = faddr_q;
    end else begin
      csr_rdata = 32'h0000_0000;
    end
  end

  // Fault log next state; a fault in the same cycle as a W1C clear wins.
  always_comb begin
    pending_d = pending_q & ~clr_s;
    kind_d    = clr_s ? 1'b0 : kind_q;
    count_d   = clr_s ? 8'd0 : count_q;
    faddr_d   = faddr_q;
    irq_en_d  = status_mod_s ? csr_wdata[16] : irq_en_q;
    if (fault_s) begin
      if (!pending_d) begin
        kind_d  = any_hit_s;
        faddr_d = mem_addr;
      end else begin
        kind_d  = kind_d;
      end
      pending_d = 1'b1;
      count_d   = (count_d == 8'd255) ? 8'd255 : count_d + 8'd1;
    end else begin
      pending_d = pending_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_sel_q     <= '0;
      q_miss_q    <= 1'b0;
      gmeta_q     <= 1'b0;
      gsync_q     <= 1'b0;
      pending_q   <= 1'b0;
      kind_q      <= 1'b0;
      count_q     <= 8'd0;
      irq_en_q    <= 1'b0;
      faddr_q     <= 32'h0000_0000;
      fault_irq_q <= 1'b0;
    end else begin
      q_sel_q     <= sel_s;
      q_miss_q    <= ~any_hit_s;
      gmeta_q     <= grubby_switch;
      gsync_q     <= gmeta_q;
      pending_q   <= pending_d;
      kind_q      <= kind_d;
      count_q     <= count_d;
      irq_en_q    <= irq_en_d;
      faddr_q     <= faddr_d;
      fault_irq_q <= pending_q & irq_en_q;
    end
  end

  assign fault_irq = fault_irq_q;

endmodule

// File: tb/tb_mem_region_mux.sv
// Directed self-checking bench for mem_region_mux with default parameters.
module tb_mem_region_mux;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_valid, mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rgrubby;
  logic [1:0]  slv_write;
  logic [63:0] slv_rdata;
  logic [1:0]  slv_rgrubby;
  logic        grubby_switch;
  logic        csr_read;
  logic [2:0]  csr_modify;
  logic [31:0] csr_wdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_valid;
  logic        fault_irq;

  int checks = 0;
  int errors = 0;

  mem_region_mux dut (
    .clk(clk), .rstn(rstn),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rgrubby(mem_rgrubby),
    .slv_write(slv_write), .slv_rdata(slv_rdata), .slv_rgrubby(slv_rgrubby),
    .grubby_switch(grubby_switch),
    .csr_read(csr_read), .csr_modify(csr_modify), .csr_wdata(csr_wdata),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_valid(csr_valid),
    .fault_irq(fault_irq)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d, output logic v);
    csr_addr = a; csr_read = 1'b1; csr_modify = 3'd0;
    #1;
    d = csr_rdata; v = csr_valid;
    csr_read = 1'b0;
    #1;
  endtask

  task automatic csr_wr(input logic [31:0] w);
    csr_addr = 12'hBC3; csr_modify = 3'd1; csr_wdata = w;
    tick;
    csr_modify = 3'd0; csr_wdata = 32'h0;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic v;
    rstn = 1'b0;
    slv_rdata = {32'h0000_1234, 32'hCAFE_F00D};
    tick; tick;
    checks++; if (mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL reset_rdata got %h exp %h", mem_rdata, 32'hCAFE_F00D); end
    checks++; if (mem_rgrubby !== 1'b0 || fault_irq !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", mem_rgrubby, fault_irq); end
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL reset_status got %h/%b exp 0/1", d, v); end
    csr_rd(12'hBC4, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_faddr got %h exp 0", d); end
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_csr_claim;
    logic [31:0] d; logic v;
    csr_rd(12'hBC5, d, v);
    checks++; if (v !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL csr_unclaimed got %h/%b exp 0/0", d, v); end
    csr_addr = 12'hBC4; #1;
    checks++; if (csr_valid !== 1'b0 || csr_rdata !== 32'h0) begin errors++; $display("FAIL csr_idle got %h/%b exp 0/0", csr_rdata, csr_valid); end
  endtask

  task automatic test_read;
    slv_rdata = {32'h0000_1234, 32'hAAAA_5555};
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = 32'h0000_0010;
    tick;
    mem_addr = 32'h0002_0004;
    checks++; if (mem_rdata !== 32'hAAAA_5555) begin errors++; $display("FAIL read_r0 got %h exp %h", mem_rdata, 32'hAAAA_5555); end
    tick;
    mem_valid = 1'b0;
    checks++; if (mem_rdata !== 32'h0000_1234) begin errors++; $display("FAIL read_r1 got %h exp %h", mem_rdata, 32'h0000_1234); end
  endtask

  task automatic test_write;
    logic [31:0] d; logic v;
    mem_valid = 1'b1; mem_write = 1'b1; mem_addr = 32'h0000_0100;
    #1;
    checks++; if (slv_write !== 2'b01) begin errors++; $display("FAIL write_r0 got %b exp 01", slv_write); end
    tick;
    mem_addr = 32'h0002_0000;
    #1;
    checks++; if (slv_write !== 2'b00) begin errors++; $display("FAIL write_ro got %b exp 00", slv_write); end
    tick;
    mem_valid = 1'b0; mem_write = 1'b0;
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0000_0103) begin errors++; $display("FAIL ro_status got %h exp %h", d, 32'h0000_0103); end
    csr_rd(12'hBC4, d, v);
    checks++; if (d !== 32'h0002_0000) begin errors++; $display("FAIL ro_faddr got %h exp %h", d, 32'h0002_0000); end
    csr_wr(32'h0000_0001);
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_status got %h exp 0", d); end
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic v;
    slv_rdata = {32'h1111_1111, 32'h2222_2222};
    mem_valid = 1'b1; mem_addr = 32'h1000_0000;
    tick;
    mem_addr = 32'h2000_0000;
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_rdata got %h exp 0", mem_rdata); end
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0000_0101) begin errors++; $display("FAIL unmapped_status got %h exp %h", d, 32'h0000_0101); end
    tick;
    mem_valid = 1'b0;
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0000_0201) begin errors++; $display("FAIL second_status got %h exp %h", d, 32'h0000_0201); end
    csr_rd(12'hBC4, d, v);
    checks++; if (d !== 32'h1000_0000) begin errors++; $display("FAIL frozen_faddr got %h exp %h", d, 32'h1000_0000); end
    csr_wr(32'h0000_0001);
  endtask

  task automatic test_saturate_irq;
    logic [31:0] d; logic v;
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = 32'h3000_0000;
    for (int i = 0; i < 300; i++) begin
      tick;
      mem_addr = 32'h3000_0100;
    end
    mem_valid = 1'b0;
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0000_FF01) begin errors++; $display("FAIL sat_status got %h exp %h", d, 32'h0000_FF01); end
    csr_rd(12'hBC4, d, v);
    checks++; if (d !== 32'h3000_0000) begin errors++; $display("FAIL sat_faddr got %h exp %h", d, 32'h3000_0000); end
    csr_wr(32'h0001_0001);
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0001_0000) begin errors++; $display("FAIL clr_irqen got %h exp %h", d, 32'h0001_0000); end
    tick;
    mem_valid = 1'b1; mem_addr = 32'h4000_0000;
    tick;
    mem_valid = 1'b0;
    checks++; if (fault_irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", fault_irq); end
    tick;
    checks++; if (fault_irq !== 1'b1) begin errors++; $display("FAIL irq_late got %b exp 1", fault_irq); end
    csr_wr(32'h0000_0001);
    tick;
  endtask

  task automatic test_grubby;
    slv_rgrubby = 2'b11; grubby_switch = 1'b1;
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = 32'h0000_0010;
    tick;
    checks++; if (mem_rgrubby !== 1'b0) begin errors++; $display("FAIL grubby_sync1 got %b exp 0", mem_rgrubby); end
    tick;
    checks++; if (mem_rgrubby !== 1'b1) begin errors++; $display("FAIL grubby_r0 got %b exp 1", mem_rgrubby); end
    mem_addr = 32'h0002_0004;
    tick;
    checks++; if (mem_rgrubby !== 1'b0) begin errors++; $display("FAIL grubby_r1 got %b exp 0", mem_rgrubby); end
    mem_addr = 32'h0000_0010; grubby_switch = 1'b0;
    tick; tick;
    mem_valid = 1'b0;
    checks++; if (mem_rgrubby !== 1'b0) begin errors++; $display("FAIL grubby_off got %b exp 0", mem_rgrubby); end
    slv_rgrubby = 2'b00;
  endtask

  task automatic test_fault_clear_race;
    logic [31:0] d; logic v;
    mem_valid = 1'b1; mem_addr = 32'h5000_0000;
    tick;
    mem_write = 1'b1; mem_addr = 32'h0002_0010;
    csr_addr = 12'hBC3; csr_modify = 3'd1; csr_wdata = 32'h0000_0001;
    tick;
    mem_valid = 1'b0; mem_write = 1'b0; csr_modify = 3'd0; csr_wdata = 32'h0;
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0000_0103) begin errors++; $display("FAIL race_status got %h exp %h", d, 32'h0000_0103); end
    csr_rd(12'hBC4, d, v);
    checks++; if (d !== 32'h0002_0010) begin errors++; $display("FAIL race_faddr got %h exp %h", d, 32'h0002_0010); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic v;
    csr_wr(32'h0001_0000);
    slv_rdata = {32'h0000_BEEF, 32'h0000_F00D};
    mem_valid = 1'b1; mem_addr = 32'h0002_0004;
    tick;
    checks++; if (fault_irq !== 1'b1 || mem_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL premid got %b/%h exp 1/0000beef", fault_irq, mem_rdata); end
    #2;
    rstn = 1'b0; mem_valid = 1'b0;
    #1;
    checks++; if (mem_rdata !== 32'h0000_F00D || mem_rgrubby !== 1'b0 || fault_irq !== 1'b0 || slv_write !== 2'b00) begin
      errors++; $display("FAIL midreset got %h/%b/%b/%b exp 0000f00d/0/0/00", mem_rdata, mem_rgrubby, fault_irq, slv_write);
    end
    csr_rd(12'hBC3, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status got %h exp 0", d); end
    tick;
    rstn = 1'b1;
    tick;
  endtask

  initial begin
    rstn = 1'b0; mem_valid = 1'b0; mem_write = 1'b0; mem_addr = 32'h0;
    slv_rdata = 64'h0; slv_rgrubby = 2'b00; grubby_switch = 1'b0;
    csr_read = 1'b0; csr_modify = 3'd0; csr_wdata = 32'h0; csr_addr = 12'h0;
    test_reset;
    test_csr_claim;
    test_read;
    test_write;
    test_unmapped;
    test_saturate_irq;
    test_grubby;
    test_fault_clear_race;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
